// File: rtl/bellek_pkg.sv
// Shared definitions for the two-requester memory arbiter: controller states
// and default bus widths.
package bellek_pkg;

    localparam int ADRES_BIT_VARS = 32;
    localparam int VERI_BIT_VARS  = 128;

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        GONDER = 2'd1,
        YANIT  = 2'd2
    } durum_t;

endpackage

// File: rtl/rr_secici.sv
// Two-way round-robin winner select: a lone valid requester always wins,
// a tie goes to the requester named by oncelik.
module rr_secici (
    input  logic [1:0] gecerli,
    input  logic       oncelik,
    output logic       kazanan,
    output logic       kazanan_var
);

    always_comb begin
        kazanan_var = |gecerli;
        if (&gecerli) begin
            kazanan = oncelik;
        end else begin
            kazanan = gecerli[1];
        end
    end

endmodule

// File: rtl/bellek_hakem.sv
// Arbiter sharing one main-memory port between two requesters, one memory
// transaction outstanding at a time, round-robin on ties.
module bellek_hakem
    import bellek_pkg::*;
#(
    parameter int ADRES_BIT = ADRES_BIT_VARS,
    parameter int VERI_BIT  = VERI_BIT_VARS
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2*ADRES_BIT-1:0] k_istek_adres_i,
    input  logic [2*VERI_BIT-1:0]  k_istek_veri_i,
    input  logic [1:0]             k_istek_gecerli_i,
    input  logic [1:0]             k_istek_yaz_gecerli_i,
    output logic [1:0]             k_istek_hazir_o,
    output logic [VERI_BIT-1:0]    k_yanit_veri_o,
    output logic [1:0]             k_yanit_gecerli_o,
    input  logic [1:0]             k_yanit_hazir_i,
    output logic [ADRES_BIT-1:0]   bellek_istek_adres_o,
    output logic [VERI_BIT-1:0]    bellek_istek_veri_o,
    output logic                   bellek_istek_gecerli_o,
    output logic                   bellek_istek_yaz_gecerli_o,
    input  logic                   bellek_istek_hazir_i,
    input  logic [VERI_BIT-1:0]    bellek_yanit_veri_i,
    input  logic                   bellek_yanit_gecerli_i,
    output logic                   bellek_yanit_hazir_o,
    output durum_t                 durum_o
);

    // Every channel is valid/ready: a transfer happens on the rising edge where
    // both are high; the source holds its payload stable while valid waits.

    durum_t                durum, durum_sonraki;
    logic                  oncelik_r;
    logic                  sahip_r;
    logic [ADRES_BIT-1:0]  adres_r;
    logic [VERI_BIT-1:0]   veri_r;
    logic                  yaz_r;

    logic                  kazanan;
    logic                  kazanan_var;
    logic                  istek_el;
    logic                  yanit_el;

    rr_secici u_secici (
        .gecerli     (k_istek_gecerli_i),
        .oncelik     (oncelik_r),
        .kazanan     (kazanan),
        .kazanan_var (kazanan_var)
    );

    assign istek_el = |(k_istek_hazir_o & k_istek_gecerli_i);
    assign yanit_el = (durum == YANIT) && bellek_yanit_gecerli_i && k_yanit_hazir_i[sahip_r];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum     <= BOSTA;
            oncelik_r <= 1'b0;
            sahip_r   <= 1'b0;
            adres_r   <= '0;
            veri_r    <= '0;
            yaz_r     <= 1'b0;
        end else begin
            durum <= durum_sonraki;
            if (istek_el) begin
                adres_r   <= kazanan ? k_istek_adres_i[ADRES_BIT +: ADRES_BIT]
                                     : k_istek_adres_i[0 +: ADRES_BIT];
                veri_r    <= kazanan ? k_istek_veri_i[VERI_BIT +: VERI_BIT]
                                     : k_istek_veri_i[0 +: VERI_BIT];
                yaz_r     <= k_istek_yaz_gecerli_i[kazanan];
                sahip_r   <= kazanan;
                oncelik_r <= ~kazanan;
            end
        end
    end

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            BOSTA:   if (istek_el) durum_sonraki = GONDER;
            GONDER:  if (bellek_istek_hazir_i) durum_sonraki = yaz_r ? BOSTA : YANIT;
            YANIT:   if (yanit_el) durum_sonraki = BOSTA;
            default: durum_sonraki = BOSTA;
        endcase
    end

    // Outputs are forced idle while rst_i is high so nothing handshakes during reset.
    always_comb begin
        k_istek_hazir_o        = 2'b00;
        k_yanit_gecerli_o      = 2'b00;
        bellek_istek_gecerli_o = 1'b0;
        bellek_yanit_hazir_o   = 1'b0;
        if (!rst_i) begin
            case (durum)
                BOSTA: begin
                    if (kazanan_var) k_istek_hazir_o[kazanan] = 1'b1;
                end
                GONDER: begin
                    bellek_istek_gecerli_o = 1'b1;
                end
                YANIT: begin
                    k_yanit_gecerli_o[sahip_r] = bellek_yanit_gecerli_i;
                    bellek_yanit_hazir_o       = k_yanit_hazir_i[sahip_r];
                end
                default: ;
            endcase
        end
    end

    assign bellek_istek_adres_o       = adres_r;
    assign bellek_istek_veri_o        = veri_r;
    assign bellek_istek_yaz_gecerli_o = yaz_r;
    assign k_yanit_veri_o             = bellek_yanit_veri_i;
    assign durum_o                    = durum;

endmodule

// File: tb/tb_bellek_hakem.sv
// Bench for bellek_hakem: directed scenarios, then randomized traffic checked
// every cycle against a transaction-level model and a simple memory stub.
module tb_bellek_hakem;
    import bellek_pkg::*;

    localparam int AB = 32;
    localparam int VB = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*AB-1:0] k_istek_adres_i       = '0;
    logic [2*VB-1:0] k_istek_veri_i        = '0;
    logic [1:0]      k_istek_gecerli_i     = '0;
    logic [1:0]      k_istek_yaz_gecerli_i = '0;
    logic [1:0]      k_istek_hazir_o;
    logic [VB-1:0]   k_yanit_veri_o;
    logic [1:0]      k_yanit_gecerli_o;
    logic [1:0]      k_yanit_hazir_i       = '0;
    logic [AB-1:0]   bellek_istek_adres_o;
    logic [VB-1:0]   bellek_istek_veri_o;
    logic            bellek_istek_gecerli_o;
    logic            bellek_istek_yaz_gecerli_o;
    logic            bellek_istek_hazir_i  = 1'b0;
    logic [VB-1:0]   bellek_yanit_veri_i   = '0;
    logic            bellek_yanit_gecerli_i = 1'b0;
    logic            bellek_yanit_hazir_o;
    durum_t          durum_o;

    bellek_hakem #(.ADRES_BIT(AB), .VERI_BIT(VB)) dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .k_istek_adres_i            (k_istek_adres_i),
        .k_istek_veri_i             (k_istek_veri_i),
        .k_istek_gecerli_i          (k_istek_gecerli_i),
        .k_istek_yaz_gecerli_i      (k_istek_yaz_gecerli_i),
        .k_istek_hazir_o            (k_istek_hazir_o),
        .k_yanit_veri_o             (k_yanit_veri_o),
        .k_yanit_gecerli_o          (k_yanit_gecerli_o),
        .k_yanit_hazir_i            (k_yanit_hazir_i),
        .bellek_istek_adres_o       (bellek_istek_adres_o),
        .bellek_istek_veri_o        (bellek_istek_veri_o),
        .bellek_istek_gecerli_o     (bellek_istek_gecerli_o),
        .bellek_istek_yaz_gecerli_o (bellek_istek_yaz_gecerli_o),
        .bellek_istek_hazir_i       (bellek_istek_hazir_i),
        .bellek_yanit_veri_i        (bellek_yanit_veri_i),
        .bellek_yanit_gecerli_i     (bellek_yanit_gecerli_i),
        .bellek_yanit_hazir_o       (bellek_yanit_hazir_o),
        .durum_o                    (durum_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic kontrol(input string ad, input logic [VB-1:0] got, input logic [VB-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", ad, got, exp);
        end
    endtask

    function automatic logic [VB-1:0] varsayilan(input logic [AB-1:0] a);
        return {4{a ^ 32'hC0DE_0000}};
    endfunction

    // ---------------- memory stub (shares reset with the arbiter) ----------------
    logic [VB-1:0] mem_store [logic [AB-1:0]];
    bit            rd_pending = 0;
    bit            rsp_up     = 0;
    logic [AB-1:0] rd_addr    = '0;
    int            mem_pct    = 100;

    function automatic logic [VB-1:0] mem_oku(input logic [AB-1:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return varsayilan(a);
    endfunction

    always begin
        @(posedge clk);
        #1;
        bellek_istek_hazir_i = (32'($urandom_range(0, 99)) < mem_pct);
        if (rd_pending) begin
            if (!rsp_up) rsp_up = (32'($urandom_range(0, 99)) < mem_pct);
            bellek_yanit_gecerli_i = rsp_up;
            bellek_yanit_veri_i    = mem_oku(rd_addr);
        end else begin
            bellek_yanit_gecerli_i = 1'($urandom_range(0, 1));
            bellek_yanit_veri_i    = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        if (rst) begin
            rd_pending = 0;
            rsp_up     = 0;
        end else begin
            if (rd_pending && bellek_yanit_gecerli_i && bellek_yanit_hazir_o) begin
                rd_pending = 0;
                rsp_up     = 0;
            end
            if (bellek_istek_gecerli_o && bellek_istek_hazir_i) begin
                if (bellek_istek_yaz_gecerli_o) begin
                    mem_store[bellek_istek_adres_o] = bellek_istek_veri_o;
                end else begin
                    rd_pending = 1;
                    rd_addr    = bellek_istek_adres_o;
                end
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    bit            m_busy = 0, m_mem_done = 0, m_yaz = 0, m_prio = 0;
    int            m_own = 0;
    logic [AB-1:0] m_adres = '0;
    logic [VB-1:0] m_veri = '0, m_exp = '0, son_yanit = '0;
    logic [VB-1:0] ref_mem [logic [AB-1:0]];
    int            olay_q[$];
    logic [AB-1:0] mem_adres_q[$];
    int            izin_sayac = 0;
    int            k0_yanit_sayac = 0;

    function automatic logic [VB-1:0] ref_oku(input logic [AB-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return varsayilan(a);
    endfunction

    always @(negedge clk) begin
        logic [1:0] e_hazir, e_kyg;
        logic       e_bg, e_byh, yanit_bekle;
        int         w;
        durum_t     e_durum;
        kontrol("veri_passthru", k_yanit_veri_o, bellek_yanit_veri_i);
        if (k_yanit_gecerli_o[0]) k0_yanit_sayac++;
        if (rst) begin
            kontrol("rst_k_hazir", VB'(k_istek_hazir_o), '0);
            kontrol("rst_b_gecerli", VB'(bellek_istek_gecerli_o), '0);
            kontrol("rst_b_hazir", VB'(bellek_yanit_hazir_o), '0);
            kontrol("rst_k_gecerli", VB'(k_yanit_gecerli_o), '0);
            m_busy = 0; m_mem_done = 0; m_prio = 0;
        end else begin
            e_hazir = 2'b00;
            w = 0;
            if (!m_busy && k_istek_gecerli_i != 2'b00) begin
                w = (k_istek_gecerli_i == 2'b11) ? int'(m_prio) : (k_istek_gecerli_i[1] ? 1 : 0);
                e_hazir[w] = 1'b1;
            end
            e_bg        = m_busy && !m_mem_done;
            yanit_bekle = m_busy && m_mem_done && !m_yaz;
            e_kyg = 2'b00;
            e_byh = 1'b0;
            if (yanit_bekle) begin
                e_kyg[m_own] = bellek_yanit_gecerli_i;
                e_byh        = k_yanit_hazir_i[m_own];
            end
            e_durum = !m_busy ? BOSTA : (!m_mem_done ? GONDER : YANIT);
            kontrol("k_istek_hazir", VB'(k_istek_hazir_o), VB'(e_hazir));
            kontrol("b_istek_gecerli", VB'(bellek_istek_gecerli_o), VB'(e_bg));
            kontrol("k_yanit_gecerli", VB'(k_yanit_gecerli_o), VB'(e_kyg));
            kontrol("b_yanit_hazir", VB'(bellek_yanit_hazir_o), VB'(e_byh));
            kontrol("durum", VB'(durum_o), VB'(e_durum));
            if (e_bg) begin
                kontrol("b_adres", VB'(bellek_istek_adres_o), VB'(m_adres));
                kontrol("b_veri", bellek_istek_veri_o, m_veri);
                kontrol("b_yaz", VB'(bellek_istek_yaz_gecerli_o), VB'(m_yaz));
            end
            if (e_hazir != 2'b00 && k_istek_gecerli_i[w]) begin
                m_busy = 1; m_mem_done = 0; m_own = w; m_prio = (w == 0);
                m_adres = k_istek_adres_i[w*AB +: AB];
                m_veri  = k_istek_veri_i[w*VB +: VB];
                m_yaz   = k_istek_yaz_gecerli_i[w];
                olay_q.push_back(w);
                izin_sayac++;
            end else if (e_bg && bellek_istek_hazir_i) begin
                mem_adres_q.push_back(bellek_istek_adres_o);
                if (m_yaz) begin
                    ref_mem[m_adres] = m_veri;
                    m_busy = 0;
                end else begin
                    m_exp = ref_oku(m_adres);
                    m_mem_done = 1;
                end
            end else if (yanit_bekle && bellek_yanit_gecerli_i && k_yanit_hazir_i[m_own]) begin
                kontrol("yanit_veri", k_yanit_veri_o, m_exp);
                son_yanit = k_yanit_veri_o;
                olay_q.push_back(2 + m_own);
                m_busy = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic saat(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sifirla();
        rst = 1'b1;
        saat(2);
        rst = 1'b0;
    endtask

    task automatic istek_sur(input int k, input bit gec, input bit yaz,
                             input logic [AB-1:0] a, input logic [VB-1:0] v);
        k_istek_gecerli_i[k]     = gec;
        k_istek_yaz_gecerli_i[k] = yaz;
        k_istek_adres_i[k*AB +: AB] = a;
        k_istek_veri_i[k*VB +: VB]  = v;
    endtask

    task automatic tekli(input int k, input bit yaz, input logic [AB-1:0] a, input logic [VB-1:0] v);
        int n0;
        n0 = izin_sayac;
        istek_sur(k, 1'b1, yaz, a, v);
        for (int i = 0; i < 50 && izin_sayac == n0; i++) saat(1);
        kontrol("grant_timeout", VB'(izin_sayac != n0), VB'(1));
        istek_sur(k, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic bos_bekle();
        for (int i = 0; i < 200 && m_busy; i++) saat(1);
        kontrol("idle_timeout", VB'(m_busy), '0);
    endtask

    // ---------------- scenarios ----------------
    logic [VB-1:0] aa = {16{8'hAA}};
    logic [VB-1:0] tut;
    int            exp_t2[4] = '{0, 2, 1, 3};
    int            exp_t3[4] = '{0, 1, 0, 1};

    initial begin
        int n, k0c, g;
        int izinler[$];
        saat(3);
        rst = 1'b0;
        mem_pct = 100;
        k_yanit_hazir_i = 2'b11;

        // k0 writes AA.. to 0x100, k1 reads it back
        sifirla();
        k0c = k0_yanit_sayac;
        tekli(0, 1'b1, 32'h100, aa);
        bos_bekle();
        tekli(1, 1'b0, 32'h100, '0);
        bos_bekle();
        kontrol("t1_owner", VB'(olay_q[$]), VB'(3));
        kontrol("t1_data", son_yanit, aa);
        kontrol("t1_k0_silent", VB'(k0_yanit_sayac - k0c), '0);

        // simultaneous reads after reset: k0 fully completes before k1 is accepted
        sifirla();
        n = olay_q.size();
        istek_sur(0, 1'b1, 1'b0, 32'h200, '0);
        istek_sur(1, 1'b1, 1'b0, 32'h300, '0);
        for (int i = 0; i < 100 && olay_q.size() < n + 4; i++) begin
            saat(1);
            for (int j = n; j < olay_q.size(); j++) begin
                if (olay_q[j] < 2) istek_sur(olay_q[j], 1'b0, 1'b0, '0, '0);
            end
        end
        istek_sur(0, 1'b0, 1'b0, '0, '0);
        istek_sur(1, 1'b0, 1'b0, '0, '0);
        kontrol("t2_count", VB'(olay_q.size() - n), VB'(4));
        if (olay_q.size() >= n + 4) begin
            for (int j = 0; j < 4; j++) kontrol("t2_order", VB'(olay_q[n+j]), VB'(exp_t2[j]));
        end

        // both continuously valid: grants alternate
        sifirla();
        n = olay_q.size();
        istek_sur(0, 1'b1, 1'b0, 32'h400, '0);
        istek_sur(1, 1'b1, 1'b0, 32'h410, '0);
        g = 0;
        for (int i = 0; i < 200 && g < 4; i++) begin
            saat(1);
            g = 0;
            for (int j = n; j < olay_q.size(); j++) if (olay_q[j] < 2) g++;
        end
        istek_sur(0, 1'b0, 1'b0, '0, '0);
        istek_sur(1, 1'b0, 1'b0, '0, '0);
        bos_bekle();
        izinler.delete();
        for (int j = n; j < olay_q.size(); j++) if (olay_q[j] < 2) izinler.push_back(olay_q[j]);
        kontrol("t3_count", VB'(izinler.size()), VB'(4));
        if (izinler.size() >= 4) begin
            for (int j = 0; j < 4; j++) kontrol("t3_order", VB'(izinler[j]), VB'(exp_t3[j]));
        end

        // k1 read held under response backpressure for 10 cycles
        k_yanit_hazir_i = 2'b00;
        tekli(1, 1'b0, 32'h120, '0);
        for (int i = 0; i < 20 && !k_yanit_gecerli_o[1]; i++) saat(1);
        istek_sur(0, 1'b1, 1'b0, 32'h130, '0);
        tut = k_yanit_veri_o;
        kontrol("t4_val", tut, {4{32'h0000_0120 ^ 32'hC0DE_0000}});
        for (int i = 0; i < 10; i++) begin
            kontrol("t4_gecerli", VB'(k_yanit_gecerli_o), VB'(2'b10));
            kontrol("t4_veri", k_yanit_veri_o, tut);
            kontrol("t4_hazir", VB'(k_istek_hazir_o), '0);
            saat(1);
        end
        n = olay_q.size();
        k_yanit_hazir_i = 2'b10;
        istek_sur(0, 1'b0, 1'b0, '0, '0);
        saat(1);
        kontrol("t4_done_n", VB'(olay_q.size() - n), VB'(1));
        kontrol("t4_done", VB'(olay_q[$]), VB'(3));

        // reset while waiting for the response, then a clean k1 read of 0x105
        k_yanit_hazir_i = 2'b00;
        tekli(1, 1'b0, 32'h140, '0);
        for (int i = 0; i < 20 && !m_mem_done; i++) saat(1);
        kontrol("t5_in_yanit", VB'(durum_o), VB'(YANIT));
        n = olay_q.size();
        rst = 1'b1;
        saat(1);
        rst = 1'b0;
        #1;
        kontrol("t5_k_hazir", VB'(k_istek_hazir_o), '0);
        kontrol("t5_b_gecerli", VB'(bellek_istek_gecerli_o), '0);
        kontrol("t5_b_hazir", VB'(bellek_yanit_hazir_o), '0);
        kontrol("t5_k_gecerli", VB'(k_yanit_gecerli_o), '0);
        kontrol("t5_durum", VB'(durum_o), VB'(BOSTA));
        k_yanit_hazir_i = 2'b11;
        tekli(1, 1'b0, 32'h105, '0);
        bos_bekle();
        kontrol("t5_adres", VB'(mem_adres_q[$]), VB'(32'h105));
        kontrol("t5_events", VB'(olay_q.size() - n), VB'(2));
        kontrol("t5_resp", VB'(olay_q[$]), VB'(3));
        kontrol("t5_data", son_yanit, {4{32'h0000_0105 ^ 32'hC0DE_0000}});

        // randomized traffic
        mem_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < 2; k++) begin
                istek_sur(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          32'h100 + (32'($urandom_range(0, 7)) << 4),
                          {$urandom, $urandom, $urandom, $urandom});
            end
            k_yanit_hazir_i = 2'($urandom_range(0, 3));
            saat(1);
        end
        rst = 1'b0;
        istek_sur(0, 1'b0, 1'b0, '0, '0);
        istek_sur(1, 1'b0, 1'b0, '0, '0);
        k_yanit_hazir_i = 2'b11;
        mem_pct = 100;
        bos_bekle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bellek_hakem.md
BELLEK_HAKEM -- requirements
Module: bellek_hakem

Interface
REQ-001 SHALL have parameter ADRES_BIT, default 32: request address width.
REQ-002 SHALL have parameter VERI_BIT, default 128: block data width (one 16-byte block).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-006 SHALL have port k_istek_adres_i  input  2*ADRES_BIT  requester n address at [n*ADRES_BIT +: ADRES_BIT].
REQ-007 SHALL have port k_istek_veri_i  input  2*VERI_BIT  requester n write data at [n*VERI_BIT +: VERI_BIT].
REQ-008 SHALL have port k_istek_gecerli_i  input  2  request valid per requester.
REQ-009 SHALL have port k_istek_yaz_gecerli_i  input  2  1 = write, 0 = read, per requester.
REQ-010 SHALL have port k_istek_hazir_o  output  2  request accepted per requester.
REQ-011 SHALL have port k_yanit_veri_o  output  VERI_BIT  read data, shared by both requesters.
REQ-012 SHALL have port k_yanit_gecerli_o  output  2  response valid per requester.
REQ-013 SHALL have port k_yanit_hazir_i  input  2  response ready per requester.
REQ-014 SHALL have port bellek_istek_adres_o  output  ADRES_BIT  address to main memory.
REQ-015 SHALL have port bellek_istek_veri_o  output  VERI_BIT  write data to memory.
REQ-016 SHALL have port bellek_istek_gecerli_o  output  1  memory request valid.
REQ-017 SHALL have port bellek_istek_yaz_gecerli_o  output  1  memory write flag.
REQ-018 SHALL have port bellek_istek_hazir_i  input  1  memory request ready.
REQ-019 SHALL have port bellek_yanit_veri_i  input  VERI_BIT  memory read data.
REQ-020 SHALL have port bellek_yanit_gecerli_i  input  1  memory response valid.
REQ-021 SHALL have port bellek_yanit_hazir_o  output  1  memory response ready.

Function
REQ-022 SHALL implement states BOSTA, GONDER, YANIT, with one memory transaction outstanding at a time.
REQ-023 In BOSTA, SHALL select the winner: a single valid requester always wins; if both are valid, requester oncelik_r wins.
REQ-024 In BOSTA, SHALL drive k_istek_hazir_o[winner]=1 combinationally, and 0 for the loser and in every other state.
REQ-025 On requester handshake (gecerli & hazir), SHALL latch address, data and write flag, record sahip_r=winner, set oncelik_r=1-winner, and enter GONDER.
REQ-026 Requester valid may drop before acceptance; nothing is latched without a handshake.
REQ-027 In GONDER, SHALL drive bellek_istek_gecerli_o=1 with latched fields (address unmodified) from the cycle after acceptance until bellek_istek_hazir_i=1.
REQ-028 On memory handshake, SHALL go to BOSTA if write (no response expected) or to YANIT if read.
REQ-029 In YANIT, SHALL drive k_yanit_gecerli_o[sahip_r]=bellek_yanit_gecerli_i and bellek_yanit_hazir_o=k_yanit_hazir_i[sahip_r]; the other requester's bits SHALL be 0.
REQ-030 k_yanit_veri_o SHALL equal bellek_yanit_veri_i at all times.
REQ-031 On response handshake, SHALL return to BOSTA; the next arbitration may accept in that BOSTA cycle.
REQ-032 Outside YANIT, bellek_yanit_hazir_o=0 and k_yanit_gecerli_o=0; memory response valid SHALL be ignored.
REQ-033 Response backpressure SHALL hold YANIT indefinitely with no new request accepted.

Reset
REQ-034 On rst_i, SHALL enter BOSTA, clear oncelik_r, sahip_r and latched fields to 0, and keep bellek_istek_gecerli_o=0 and bellek_yanit_hazir_o=0 during reset.
REQ-035 Reset mid-GONDER/YANIT SHALL abandon the transaction with no response delivered; main memory shares rst_i.

Structure
REQ-036 State encodings and ADRES_BIT/VERI_BIT defaults SHALL live in shared package bellek_pkg.
REQ-037 Winner selection SHALL be a combinational sub-module rr_secici (inputs: gecerli[1:0], oncelik; outputs: kazanan, var).

Verification
REQ-038 k0 writes 0x100 with data 128'hAA..AA, then k1 reads 0x100 -> k1 receives 128'hAA..AA; k_yanit_gecerli_o[0] never asserts.
REQ-039 After reset, k0 reads 0x200 and k1 reads 0x300 in the same cycle -> k0 is accepted first and its response completes before k1 is accepted.
REQ-040 Both requesters continuously valid for 4 reads -> grants alternate in order 0,1,0,1.
REQ-041 k1 read with k_yanit_hazir_i[1]=0 for 10 cycles -> k_yanit_gecerli_o[1] is held with stable data, k_istek_hazir_o=2'b00 throughout, and the handshake completes in the cycle ready rises.
REQ-042 rst_i asserted in YANIT -> next cycle all valid/ready outputs are 0 and state is BOSTA; a following k1 read of 0x105 reaches memory with address 0x105 and completes normally.
